// File: rtl/lsu.sv
// Purpose: load/store unit that turns byte/half/word accesses into aligned word bus transactions.
// Latency: accept at cycle 0, mem_req at 1, out_valid at 2 minimum; error/non-memory ops give out_valid at 1.
// Backpressure: in_ready only in IDLE; bus lines held until mem_gnt; result held until out_ready.
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   in_valid/in_ready               - instruction handshake (in_inst, in_addr, in_wdata)
//   out_valid/out_ready             - result handshake (out_rdata, out_err: 00 ok, 01 misaligned,
//                                     10 timeout, 11 illegal funct3)
//   mem_req/mem_gnt                 - bus request/grant (mem_wen, mem_addr, mem_wdata, mem_wmask)
//   mem_rvalid/mem_rdata            - read data or write acknowledge
module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [1:0]  out_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] cnt_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic          is_load_q;

    // ---------------- Request decode (only meaningful in IDLE) ----------------
    logic [2:0] f3;
    logic       is_load, is_store, f3_bad, misal, go_mem, accept;
    logic [1:0] dec_err;
    logic [3:0] st_mask;
    logic [31:0] st_data;

    assign f3       = in_inst[14:12];
    assign is_load  = (in_inst[6:0] == OPC_LOAD);
    assign is_store = (in_inst[6:0] == OPC_STORE);

    // Loads allow 000/001/010/100/101; stores allow 000/001/010.
    assign f3_bad = is_load  ? ((f3 == 3'b011) || (f3[2:1] == 2'b11)) :
                    is_store ? (f3 >= 3'b011) : 1'b0;

    // f3[1:0] encodes access size for every legal funct3.
    assign misal = ((f3[1:0] == 2'b01) && in_addr[0]) ||
                   ((f3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));

    assign go_mem = (is_load || is_store) && !f3_bad && !misal;
    assign accept = (state_q == S_IDLE) && in_valid;

    always_comb begin
        dec_err = 2'b00;
        if (is_load || is_store) begin
            if (f3_bad)     dec_err = 2'b11;
            else if (misal) dec_err = 2'b01;
        end
    end

    always_comb begin
        st_mask = 4'b1111;
        st_data = in_wdata;
        case (f3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << in_addr[1:0];
                st_data = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << in_addr[1:0];
                st_data = {2{in_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // ---------------- Bus completion / timeout ----------------
    logic mem_done, busy, tmo;

    assign busy     = (state_q == S_REQ) || (state_q == S_WAIT);
    assign mem_done = ((state_q == S_REQ) && mem_gnt && mem_rvalid) ||
                      ((state_q == S_WAIT) && mem_rvalid);
    // The current cycle is the TIMEOUT-th busy cycle; a completion in it still wins.
    assign tmo      = busy && !mem_done && (cnt_q == CW'(TIMEOUT - 1));

    // ---------------- Load extraction ----------------
    logic [31:0] ld_shift, ld_data;

    assign ld_shift = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_data = mem_rdata;
        case (f3_q)
            3'b000:  ld_data = {{24{ld_shift[7]}},  ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b101:  ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = mem_rdata;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = go_mem ? S_REQ : S_DONE;
            S_REQ: begin
                if (mem_done || tmo) state_d = S_DONE;
                else if (mem_gnt)    state_d = S_WAIT;
            end
            S_WAIT: if (mem_done || tmo) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // in_ready is gated by rst_n so it reads 0 while reset is held.
    always_comb begin
        in_ready  = 1'b0;
        mem_req   = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: in_ready  = rst_n;
            S_REQ:  mem_req   = 1'b1;
            S_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            is_load_q <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wmask <= 4'h0;
            out_rdata <= 32'h0;
            out_err   <= 2'b00;
        end else if (accept) begin
            cnt_q     <= '0;
            f3_q      <= f3;
            off_q     <= in_addr[1:0];
            is_load_q <= is_load;
            mem_wen   <= go_mem && is_store;
            mem_addr  <= go_mem ? {in_addr[31:2], 2'b00} : 32'h0;
            mem_wdata <= (go_mem && is_store) ? st_data : 32'h0;
            mem_wmask <= (go_mem && is_store) ? st_mask : 4'h0;
            out_rdata <= 32'h0;
            out_err   <= dec_err;
        end else if (busy) begin
            cnt_q <= cnt_q + CW'(1);
            if (mem_done) begin
                out_rdata <= is_load_q ? ld_data : 32'h0;
                out_err   <= 2'b00;
            end else if (tmo) begin
                out_rdata <= 32'h0;
                out_err   <= 2'b10;
            end
        end
    end

    // Instruction fields not used by this unit.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{in_inst[31:15], in_inst[11:7]};

endmodule

// File: doc/lsu.md
# lsu

Multi-cycle load/store unit between the execute stage and word-organised data memory in the NPC core. It takes one memory instruction at a time from execute over a valid/ready handshake and drives a request/grant/response memory bus. It converts byte/half/word accesses into aligned word transactions with byte-lane masks, and returns a sign- or zero-extended load result or an error code to write-back.

## Interface
- `TIMEOUT`, default 255: max cycles spent in REQ+WAIT before aborting; counter width `$clog2(TIMEOUT+1)`.

- `clk` in 1: single clock; all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: execute presents a request.
- `in_ready` out 1: unit can accept; high only in IDLE with `rst_n` high.
- `in_inst` in 32: instruction; opcode `[6:0]` and funct3 `[14:12]` are used.
- `in_addr` in 32: effective byte address.
- `in_wdata` in 32: store data, taken from the low bits.
- `out_valid` out 1: result available.
- `out_ready` in 1: write-back accepts the result.
- `out_rdata` out 32: extended load data; 0 for stores, non-memory ops and errors.
- `out_err` out 2: 00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
- `mem_req` out 1: memory request.
- `mem_gnt` in 1: memory accepted the request.
- `mem_wen` out 1: 1 = write.
- `mem_addr` out 32: word address `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-shifted store data.
- `mem_wmask` out 4: byte-lane enables; 0 on reads.
- `mem_rvalid` in 1: read data or write acknowledge.
- `mem_rdata` in 32: full aligned word.

## Operation
- **States:** IDLE, REQ, WAIT, DONE.
- **IDLE:** on `in_valid`, latch inst, addr and wdata, then classify:
  - Load is opcode 0000011; store is opcode 0100011.
  - Neither: go to DONE with `out_err`=00 and `out_rdata`=0. No bus access.
  - Illegal funct3 (load 011/110/111, store ≥011): go to DONE with err 11.
  - Misaligned (half with `addr[0]`=1, word with `addr[1:0]`≠0): go to DONE with err 01.
  - Otherwise go to REQ and clear the timeout counter.
- **REQ:** `mem_req`=1 and the address/data/mask lines are held stable until `mem_gnt`, then go to WAIT. If `mem_gnt` and `mem_rvalid` are both high in the same cycle, go straight to DONE.
- **WAIT:** on `mem_rvalid`, capture the result and go to DONE.
- **Timeout:** the counter increments in every REQ/WAIT cycle. When it reaches `TIMEOUT` with no completion, drop `mem_req`, go to DONE with err 10, and discard any later `mem_rvalid`.
- **DONE:** `out_valid`=1 and outputs are held stable until `out_ready`, then go to IDLE.
- **Store lanes** (o = `addr[1:0]`):
  - SB: `mem_wmask`=1<<o; `mem_wdata`=`{4{wdata[7:0]}}`.
  - SH: `mem_wmask`=4'b0011<<o; `mem_wdata`=`{2{wdata[15:0]}}`.
  - SW: `mem_wmask`=4'b1111; `mem_wdata`=wdata.
- **Load extract:** shift `mem_rdata` right by o×8, then take LB/LBU from `[7:0]` and LH/LHU from `[15:0]`, sign- or zero-extended to 32 bits. LW passes the word through.
- **Ignored inputs:** `mem_gnt` outside REQ, `mem_rvalid` outside REQ/WAIT, and `in_valid` outside IDLE.

## Timing
- **Reset (async, `rst_n` low):** state=IDLE, counter=0. `in_ready`, `out_valid`, `mem_req`, `mem_wen` are 0; `out_rdata`, `out_err`, `mem_addr`, `mem_wdata`, `mem_wmask` are 0.
- Asserting reset mid-transaction aborts the access immediately; an in-flight memory response after release is ignored.
- **Accepted-access latency:** accept at cycle 0 (handshake in IDLE); `mem_req` rises at cycle 1.
  - With `mem_gnt` and `mem_rvalid` at cycle 1: `out_valid` at cycle 2.
  - With `mem_gnt` at 1 and `mem_rvalid` at 2: `out_valid` at cycle 3.
- Error and non-memory paths: `out_valid` at cycle 1.
- `in_ready` rises the cycle after the `out_valid`&`out_ready` handshake; there is no back-to-back overlap, so throughput is at most one op per 3 cycles.
- All outputs are registered or decoded from registered state only; there is no combinational path from `in_*` or `mem_*` to outputs.

## Test plan
- **LB:** addr 0x8000_0003, `mem_rdata` 0x80AB_CDEF, gnt+rvalid at cycle 1 -> `out_rdata` 0xFFFF_FF80, err 00, `out_valid` at cycle 2. Repeat with LBU -> 0x0000_0080.
- **SH:** addr 0x8000_0002, wdata 0x1234_BEEF -> `mem_wen`=1, `mem_addr` 0x8000_0000, `mem_wmask` 4'b1100, `mem_wdata` 0xBEEF_BEEF, `out_rdata` 0.
- **Misaligned LW:** addr 0x8000_0001 -> no `mem_req`, `out_valid` at cycle 1 with err 01; LH at the same address gives err 01; LB at the same address succeeds.
- **Backpressure:** `mem_gnt` delayed 4 cycles and `out_ready` low 3 cycles -> `mem_addr`/`mem_wmask` and `out_rdata`/`out_err` stay stable throughout; `in_ready` stays low until the handshake.
- **Timeout:** `TIMEOUT`=8, `mem_gnt` high, no `mem_rvalid` -> err 10 after 8 REQ+WAIT cycles; a late `mem_rvalid` is ignored and the next LW completes correctly.
- **Reset during WAIT:** `rst_n` low -> all outputs 0 immediately; after release `in_ready`=1 and a pending `mem_rvalid` produces no `out_valid`.
